// File: rtl/seg_pkg.sv
// Shared types, glyph table and anode helpers for the seven-segment bus monitor.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned NUM_GLYPHS = 16;

    // Cathode bit positions: a..g occupy bits 7 down to 1, dp is bit 0.
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } seg_state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] hex;
    } glyph_t;

    // Lit-segment sets {a,b,c,d,e,f,g} for 0..F.
    localparam logic [6:0] GLYPHS [NUM_GLYPHS] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic glyph_t decode_glyph(input logic [SEG_W-1:0] pattern);
        glyph_t     res;
        logic [6:0] lit;
        lit = ~pattern[SEG_A:SEG_G];
        res = '0;
        for (int i = 0; i < int'(NUM_GLYPHS); i++) begin
            if (GLYPHS[i] == lit) begin
                res.legal = 1'b1;
                res.hex   = 4'(i);
            end
        end
        return res;
    endfunction

    function automatic logic anode_one_hot(input logic [NUM_DIGITS-1:0] anx);
        logic [NUM_DIGITS-1:0] act;
        act = ~anx;
        return (act != '0) && ((act & (act - 4'd1)) == '0);
    endfunction

    function automatic logic [1:0] anode_index(input logic [NUM_DIGITS-1:0] anx);
        logic [1:0] idx;
        case (anx)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of one captured cathode pattern into hex value, legality and dp.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output logic             o_legal_c,
    output logic [3:0]       o_hex_c,
    output logic             o_dp_c
);

    glyph_t w_glyph;

    always_comb begin
        w_glyph = decode_glyph(i_pattern);
    end

    assign o_legal_c = w_glyph.legal;
    assign o_hex_c   = w_glyph.hex;
    assign o_dp_c    = ~i_pattern[SEG_DP];

endmodule

// File: rtl/seg_mux_decoder.sv
// Monitors a multiplexed four-digit seven-segment bus and recovers each digit's
// pattern, hex value, dp, freshness and frame completion.
module seg_mux_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NUM_DIGITS-1:0] i_anx,
    input  logic [SEG_W-1:0]      i_cx,
    output logic [SEG_W-1:0]      o_c0,
    output logic [SEG_W-1:0]      o_c1,
    output logic [SEG_W-1:0]      o_c2,
    output logic [SEG_W-1:0]      o_c3,
    output logic [15:0]           o_hex,
    output logic [NUM_DIGITS-1:0] o_dp,
    output logic [NUM_DIGITS-1:0] o_valid,
    output logic [NUM_DIGITS-1:0] o_legal,
    output logic [NUM_DIGITS-1:0] o_update,
    output logic                  o_frame_done
);

    localparam int unsigned S_W  = NUM_DIGITS + SEG_W;
    localparam int unsigned SC_W = $clog2(STABLE_CYCLES);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [S_W-1:0]                   w_s_in;
    logic [S_W-1:0]                   r_s;
    logic                             w_change;
    logic [SC_W-1:0]                  r_stable;
    seg_state_e                       r_state;
    seg_state_e                       w_state_next;
    logic                             w_capture;
    logic [1:0]                       w_idx;
    logic [NUM_DIGITS-1:0]            w_cap_mask;
    logic                             w_legal;
    logic [3:0]                       w_hex;
    logic                             w_dp;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] r_c;
    logic [NUM_DIGITS-1:0][3:0]       r_hex;
    logic [NUM_DIGITS-1:0]            r_dp;
    logic [NUM_DIGITS-1:0]            r_legal;
    logic [NUM_DIGITS-1:0]            r_valid;
    logic [NUM_DIGITS-1:0]            r_update;
    logic [NUM_DIGITS-1:0][TO_W-1:0]  r_to;
    logic [NUM_DIGITS-1:0]            r_seen;
    logic [NUM_DIGITS-1:0]            w_seen_acc;
    logic                             r_frame_done;

    // A change is detected on the same edge the new value enters s.
    assign w_s_in   = {i_anx, i_cx};
    assign w_change = (w_s_in != r_s);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s      <= {{NUM_DIGITS{1'b1}}, {SEG_W{1'b1}}};
            r_stable <= '0;
        end else begin
            r_s <= w_s_in;
            if (w_change) begin
                r_stable <= '0;
            end else if (r_stable != SC_MAX) begin
                r_stable <= r_stable + SC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HELD only leaves on a change, giving one capture per dwell.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (w_change) begin
            w_state_next = anode_one_hot(i_anx) ? ST_SETTLE : ST_BLANK;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_stable == SC_MAX) begin
                        w_state_next = ST_HELD;
                        w_capture    = 1'b1;
                    end
                end
                ST_BLANK: w_state_next = ST_BLANK;
                ST_HELD:  w_state_next = ST_HELD;
                default:  w_state_next = ST_BLANK;
            endcase
        end
    end

    assign w_idx      = anode_index(r_s[S_W-1:SEG_W]);
    assign w_cap_mask = w_capture ? (4'b0001 << w_idx) : '0;

    seg_glyph_decode u_glyph (
        .i_pattern (r_s[SEG_W-1:0]),
        .o_legal_c (w_legal),
        .o_hex_c   (w_hex),
        .o_dp_c    (w_dp)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_c      <= {NUM_DIGITS{8'hFF}};
            r_hex    <= '0;
            r_dp     <= '0;
            r_legal  <= '0;
            r_update <= '0;
        end else begin
            r_update <= w_cap_mask;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (w_cap_mask[i]) begin
                    r_c[i]     <= r_s[SEG_W-1:0];
                    r_hex[i]   <= w_hex;
                    r_dp[i]    <= w_dp;
                    r_legal[i] <= w_legal;
                end
            end
        end
    end

    // Freshness: a capture on the expiry cycle takes priority over the timeout.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_to    <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (w_cap_mask[i]) begin
                    r_to[i]    <= '0;
                    r_valid[i] <= 1'b1;
                end else if (r_to[i] == TO_LAST) begin
                    r_to[i]    <= TO_MAX;
                    r_valid[i] <= 1'b0;
                end else if (r_to[i] != TO_MAX) begin
                    r_to[i] <= r_to[i] + TO_W'(1);
                end
            end
        end
    end

    assign w_seen_acc = r_seen | w_cap_mask;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_seen       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (w_seen_acc == 4'hF);
            r_seen       <= (w_seen_acc == 4'hF) ? '0 : w_seen_acc;
        end
    end

    assign o_c0         = r_c[0];
    assign o_c1         = r_c[1];
    assign o_c2         = r_c[2];
    assign o_c3         = r_c[3];
    assign o_hex        = r_hex;
    assign o_dp         = r_dp;
    assign o_valid      = r_valid;
    assign o_legal      = r_legal;
    assign o_update     = r_update;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Directed bench for seg_mux_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_seg_mux_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 64;

    logic        clk;
    logic        rst;
    logic [3:0]  anx;
    logic [7:0]  cx;
    logic [7:0]  c0, c1, c2, c3;
    logic [15:0] hex;
    logic [3:0]  dp, valid, legal, update;
    logic        frame_done;

    int total;
    int bad;

    seg_mux_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_anx        (anx),
        .i_cx         (cx),
        .o_c0         (c0),
        .o_c1         (c1),
        .o_c2         (c2),
        .o_c3         (c3),
        .o_hex        (hex),
        .o_dp         (dp),
        .o_valid      (valid),
        .o_legal      (legal),
        .o_update     (update),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold one bus value for n edges; update/frame_done may only fire at edge cap_k.
    task automatic dwell(input logic [3:0] a, input logic [7:0] c, input int n, input int cap_k,
                         input logic [3:0] exp_upd, input logic exp_fd, input string tag);
        anx = a;
        cx  = c;
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == cap_k) begin
                chk($sformatf("%s_upd_e%0d", tag, k), 32'(update), 32'(exp_upd));
                chk($sformatf("%s_fd_e%0d", tag, k), 32'(frame_done), 32'(exp_fd));
            end else begin
                chk($sformatf("%s_upd_e%0d", tag, k), 32'(update), 32'd0);
                chk($sformatf("%s_fd_e%0d", tag, k), 32'(frame_done), 32'd0);
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_c"}, {c3, c2, c1, c0}, 32'hFFFF_FFFF);
        chk({tag, "_hex"}, 32'(hex), 32'd0);
        chk({tag, "_dp"}, 32'(dp), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_legal"}, 32'(legal), 32'd0);
        chk({tag, "_update"}, 32'(update), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        anx   = 4'hF;
        cx    = 8'hFF;
        tick();
        tick();
        tick();
        chk_reset("por");
        rst = 1'b0;

        // Single digit "0" on AN0: one capture at edge 4.
        dwell(4'hE, 8'h03, 10, 4, 4'b0001, 1'b0, "s1");
        chk("s1_hex0", 32'(hex[3:0]), 32'h0);
        chk("s1_legal0", 32'(legal[0]), 32'd1);
        chk("s1_valid0", 32'(valid[0]), 32'd1);
        chk("s1_dp0", 32'(dp[0]), 32'd0);
        chk("s1_c0", 32'(c0), 32'h03);

        // Fresh frame: F, A, 1, 8. across AN3..AN0.
        rst = 1'b1;
        anx = 4'hF;
        cx  = 8'hFF;
        tick();
        rst = 1'b0;
        dwell(4'h7, 8'h71, 20, 4, 4'b1000, 1'b0, "s2_an3");
        dwell(4'hB, 8'h11, 20, 4, 4'b0100, 1'b0, "s2_an2");
        dwell(4'hD, 8'h9F, 20, 4, 4'b0010, 1'b0, "s2_an1");
        dwell(4'hE, 8'h00, 20, 4, 4'b0001, 1'b1, "s2_an0");
        chk("s2_hex", 32'(hex), 32'hFA18);
        chk("s2_dp", 32'(dp), 32'b0001);
        chk("s2_legal", 32'(legal), 32'hF);
        chk("s2_valid", 32'(valid), 32'b0111);
        chk("s2_c", {c3, c2, c1, c0}, 32'h7111_9F00);

        // Short dwell, then a Cx glitch restarting qualification.
        dwell(4'hD, 8'h25, 3, -1, 4'b0000, 1'b0, "s3_short");
        dwell(4'hF, 8'hFF, 2, -1, 4'b0000, 1'b0, "s3_gap");
        dwell(4'hD, 8'h25, 2, -1, 4'b0000, 1'b0, "s3_pre");
        dwell(4'hD, 8'h24, 10, 4, 4'b0010, 1'b0, "s3_glitch");
        chk("s3_c1", 32'(c1), 32'h24);
        chk("s3_hex1", 32'(hex[7:4]), 32'h2);
        chk("s3_dp1", 32'(dp[1]), 32'd1);
        chk("s3_legal1", 32'(legal[1]), 32'd1);

        // Blank pattern on AN2 is illegal but still captured; two anodes never capture.
        dwell(4'hB, 8'hFF, 10, 4, 4'b0100, 1'b0, "s4_ill");
        chk("s4_legal2", 32'(legal[2]), 32'd0);
        chk("s4_hex2", 32'(hex[11:8]), 32'h0);
        chk("s4_valid2", 32'(valid[2]), 32'd1);
        chk("s4_c2", 32'(c2), 32'hFF);
        dwell(4'hC, 8'h00, 50, -1, 4'b0000, 1'b0, "s4_two");

        // Starve digit 3 after a capture at local edge 4: valid drops at edge 68.
        dwell(4'h7, 8'h71, 10, 4, 4'b1000, 1'b0, "s5_cap");
        anx = 4'hF;
        cx  = 8'hFF;
        for (int e = 10; e <= 70; e++) begin
            tick();
            chk($sformatf("s5_valid3_e%0d", e), 32'(valid[3]), 32'(e < 68));
        end
        chk("s5_c3_kept", 32'(c3), 32'h71);
        chk("s5_hex3_kept", 32'(hex[15:12]), 32'hF);
        chk("s5_legal3_kept", 32'(legal[3]), 32'd1);

        // Recapture landing exactly on the expiry edge keeps valid high.
        dwell(4'h7, 8'h71, 10, 4, 4'b1000, 1'b0, "s5b_cap");
        dwell(4'hF, 8'hFF, 54, -1, 4'b0000, 1'b0, "s5b_gap");
        dwell(4'h7, 8'h61, 10, 4, 4'b1000, 1'b0, "s5b_land");
        chk("s5b_valid3", 32'(valid[3]), 32'd1);
        chk("s5b_hex3", 32'(hex[15:12]), 32'hE);
        chk("s5b_c3", 32'(c3), 32'h61);

        // Reset at edge 2 of an AN0 dwell; requalify from scratch afterwards.
        dwell(4'hE, 8'h49, 2, -1, 4'b0000, 1'b0, "s6_pre");
        rst = 1'b1;
        tick();
        chk_reset("s6_rst");
        rst = 1'b0;
        dwell(4'hE, 8'h49, 8, 4, 4'b0001, 1'b0, "s6_post");
        chk("s6_c0", 32'(c0), 32'h49);
        chk("s6_hex", 32'(hex), 32'h0005);
        chk("s6_valid", 32'(valid), 32'b0001);
        chk("s6_legal", 32'(legal), 32'b0001);
        chk("s6_dp", 32'(dp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
